// File: rtl/dmem_param.sv
// Parameterised single-port data memory with byte-lane writes, base-window
// decode, sticky miss flag and registered 1-cycle read path.
// Optional power-on clearing is enabled by defining DMEM_CLEAR_EN; without it
// INIT lasts a single cycle and the array powers up undefined.
module dmem_param #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH_LOG2   = 5,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned BASE_ADDRESS = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req,
    input  logic                      we,
    input  logic [DATA_WIDTH/8-1:0]   be,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic                      ready,
    output logic                      rvalid,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      err,
    input  logic                      err_clr
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned LB    = $clog2(NB);
    localparam int unsigned WIN   = DEPTH_LOG2 + LB;
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned TAGW  = ADDR_WIDTH - WIN;

    localparam logic [TAGW-1:0] BASE_TAG = TAGW'(BASE_ADDRESS);

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

`ifdef DMEM_CLEAR_EN
    logic [DEPTH_LOG2-1:0]  init_cnt;
`endif

    logic                   accept_c;
    logic                   hit_c;
    logic [DEPTH_LOG2-1:0]  offset_c;

    // Request decode: acceptance, window hit and word offset
    assign accept_c = req && ready;
    assign hit_c    = (addr[ADDR_WIDTH-1:WIN] == BASE_TAG) && (addr[LB-1:0] == '0);
    assign offset_c = addr[WIN-1:LB];

    // Control FSM, read return path and sticky error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= INIT;
            ready  <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
`ifdef DMEM_CLEAR_EN
            init_cnt <= '0;
`endif
        end else begin
            rvalid <= 1'b0;
            // a new miss wins over a simultaneous clear
            err    <= (accept_c && !hit_c) || (err && !err_clr);
            case (state)
                INIT: begin
`ifdef DMEM_CLEAR_EN
                    init_cnt <= init_cnt + DEPTH_LOG2'(1);
                    if (init_cnt == '1) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
`else
                    state <= IDLE;
                    ready <= 1'b1;
`endif
                end
                IDLE: begin
                    if (accept_c && !we) begin
                        rvalid <= 1'b1;
                        rdata  <= hit_c ? mem[offset_c] : '0;
                    end
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: init clearing and byte-lane writes, never reset
    always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
        if (state == INIT) begin
            mem[init_cnt] <= '0;
        end
`endif
        if (accept_c && we && hit_c) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (be[i]) begin
                    mem[offset_c][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/dmem_param.md
DMEM_PARAM -- requirements
Module: dmem_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; legal values 32 or 64.
REQ-002 Parameter DEPTH_LOG2, default 5, log2 of word count (DEPTH = 2**DEPTH_LOG2).
REQ-003 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-004 Parameter BASE_ADDRESS, default 0, value compared against the address bits above the array window.
REQ-005 Derived constants: NB = DATA_WIDTH/8 byte lanes; LB = log2(NB); WIN = DEPTH_LOG2+LB.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 req  input  1  transaction request.
REQ-009 we  input  1  1 = write, 0 = read; sampled with req.
REQ-010 be  input  NB  byte-lane write enables; be[i] governs wdata[8i+7:8i].
REQ-011 addr  input  ADDR_WIDTH  byte address.
REQ-012 wdata  input  DATA_WIDTH  write data.
REQ-013 ready  output  1  block accepts a request this cycle.
REQ-014 rvalid  output  1  one-cycle pulse; rdata valid.
REQ-015 rdata  output  DATA_WIDTH  registered read data.
REQ-016 err  output  1  sticky error flag.
REQ-017 err_clr  input  1  clears err.

Function
REQ-018 A request SHALL be accepted on a rising edge where req=1 and ready=1; otherwise it is ignored, with no state change.
REQ-019 Hit SHALL be defined as addr[ADDR_WIDTH-1:WIN]==BASE_ADDRESS and addr[LB-1:0]==0; word offset SHALL be addr[WIN-1:LB].
REQ-020 An accepted hit write SHALL update exactly the lanes with be[i]=1 at the accepting edge; be all-zero is a legal no-op.
REQ-021 An accepted hit read SHALL drive rdata with the word at the offset and pulse rvalid=1 on the cycle after acceptance (1-cycle latency).
REQ-022 Back-to-back: a read accepted the cycle after a write to the same word SHALL return the newly written lanes.
REQ-023 An accepted miss (base mismatch or misaligned) SHALL NOT modify the array; a miss read SHALL return rdata=0 with rvalid=1; any miss SHALL set err.
REQ-024 rdata SHALL hold its value between reads; writes SHALL NOT pulse rvalid.
REQ-025 err SHALL clear on err_clr=1; a simultaneous set and clear SHALL leave err=1.
REQ-026 State machine states: INIT (ready=0) and IDLE (ready=1); INIT->IDLE per REQ-033/034; IDLE SHALL be left only by reset.
REQ-027 In IDLE, back-to-back requests SHALL be accepted every cycle with no bubbles.

Reset
REQ-028 On reset_n=0: ready=0, rvalid=0, rdata=0, err=0, state=INIT, init counter=0, all asynchronously.
REQ-029 Reset asserted mid-INIT or mid-transaction SHALL abort it; a pending rvalid SHALL be dropped.
REQ-030 Array contents SHALL NOT be reset asynchronously.

Configuration
REQ-031 Macro DMEM_CLEAR_EN selects power-on clearing.
REQ-032 When defined, INIT SHALL write zero to word k on the k-th cycle after reset release, k = 0..DEPTH-1.
REQ-033 When defined, the SHALL transition to IDLE after word DEPTH-1 is written; ready rises DEPTH cycles after reset release; req SHALL be ignored during INIT.
REQ-034 When undefined, INIT SHALL last one cycle and array contents after reset are undefined.

Verification
REQ-035 DMEM_CLEAR_EN, defaults: release reset -> ready=0 for exactly 32 cycles, then reads of every word return 0x00000000.
REQ-036 Write 0xDEADBEEF to addr 0x8 with be=1111, then write 0x000000AA with be=0001 -> read of 0x8 returns 0xDEADBEAA, rvalid one cycle after accept.
REQ-037 Write 0x12345678 to 0x10, then read 0x10 on the next cycle -> rdata=0x12345678 one cycle later; no idle cycle between the requests.
REQ-038 Read 0x6 (misaligned), then read 0x80 (base miss) -> rdata=0 with rvalid each, err=1; err_clr=1 together with another miss -> err stays 1; err_clr alone -> err=0.
REQ-039 DATA_WIDTH=64, DEPTH_LOG2=4, BASE_ADDRESS=1: write 0x0123456789ABCDEF to 0x88 -> read 0x88 returns it; write to 0x08 -> no change, err=1.
REQ-040 Assert reset_n=0 during INIT at counter 10 -> outputs return to reset values, INIT restarts from word 0, ready rises 32 cycles after release.
